alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port arbiter and issue sequencer that shares one combinational ALU between requesters, e.g. the pipeline EX stage (port 0) and a secondary unit such as a CSR/address helper (port 1). Each cycle it grants at most one request, registers the operation onto the ALU inputs, captures the ALU result one cycle later and returns it, tagged by port, on a one-cycle response pulse. It sits between the requesters and the ALU and is the only driver of the ALU's opcode, func3, func7 and operand inputs.

## Interface
- PRIO_MODE, 0: 0 = round-robin; 1 = port 0 fixed priority with starvation guard
- STARVE_LIMIT, 4: in PRIO_MODE 1, consecutive lost cycles after which port 1 is forced a grant (range 1..15)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  kill all in-flight operations, block grants this cycle
- reqN_valid  in  1  port N (N = 0, 1) has an operation
- reqN_ready  out  1  port N granted this cycle (combinational)
- reqN_opcode  in  5  ALU opcode (instr[6:2])
- reqN_func3  in  3  ALU func3
- reqN_func7  in  1  ALU func7 (instr[30])
- reqN_op1 / reqN_op2  in  32  operands
- alu_opcode / alu_func3 / alu_func7 / alu_operand1 / alu_operand2  out  5/3/1/32/32  registered ALU inputs
- alu_result  in  32  ALU output (combinational from alu_* inputs)
- rspN_valid  out  1  one-cycle pulse: result for port N
- rsp_data  out  32  registered result, valid only while a rspN_valid is high

## Operation
- Accept on port N = reqN_valid && reqN_ready. At most one of req0_ready / req1_ready high per cycle; both low while flush = 1.
- Round-robin (PRIO_MODE 0): only one valid -> grant it. Both valid -> grant the port not in last_grant. last_grant updates only on accept. Reset: last_grant = 1 (port 0 wins first contention).
- Fixed (PRIO_MODE 1): port 0 wins contention unless starve_cnt == STARVE_LIMIT, then port 1 wins. starve_cnt (4 bits) increments each cycle req1_valid && !req1_ready && !flush, saturating at STARVE_LIMIT; clears to 0 on port-1 accept. Flush cycles neither increment nor clear it.
- Stage S1 (alu_* registers + s1_valid, s1_port): loaded from the granted port on accept; on cycles without accept alu_* hold their previous values and s1_valid = 0.
- Stage S2 (rsp_data, s2_valid, s2_port): loads rsp_data <= alu_result, s2_valid <= s1_valid, s2_port <= s1_port every cycle.
- rsp0_valid = s2_valid && s2_port == 0; rsp1_valid = s2_valid && s2_port == 1. Responses cannot be back-pressured.
- flush at edge: s1_valid and s2_valid cleared; no accept. A response already presented in the flush cycle remains valid for that cycle. starve_cnt and last_grant unaffected.
- Reset: all outputs 0 (alu_* = 0, rsp_data = 0, rspN_valid = 0, s1/s2 valid = 0), starve_cnt = 0, last_grant = 1. reqN_ready may be high during reset (combinational), but no accept is registered until rst_n deasserts.

## Timing
- Accept in cycle N -> alu_* hold the operation during N+1 -> rspN_valid and rsp_data in N+2. Fixed latency is 2 cycles.
- Throughput is one operation per cycle across both ports. Back-to-back accepts produce back-to-back responses in accept order.
- reqN_ready depends only on reqN_valid, flush and registered state. There is no combinational path from alu_result to any output.
- rst_n asserted mid-operation: all in-flight operations are dropped with no response; after release the first contention goes to port 0.
- Width rules: operands and result pass through unmodified at 32 bits. The arbiter performs no arithmetic on data.

## Test plan
- Single op: req0 {opcode 01100, func3 000, func7 0, op1 5, op2 7} accepted cycle 10 -> alu_* carry it in cycle 11; rsp0_valid = 1, rsp_data = 12 in cycle 12 only; rsp1_valid stays 0.
- Round-robin contention: both ports valid continuously for 6 cycles from reset -> grants 0,1,0,1,0,1. Responses alternate rsp0/rsp1 starting 2 cycles after the first grant.
- Fixed priority with STARVE_LIMIT 4: both valid continuously -> port 0 accepted 4 cycles, then port 1 once (starve_cnt 4 -> 0), then port 0 again, repeating.
- Flush: accepts at cycles 20 and 21, flush = 1 in cycle 22 -> the cycle-20 response is still seen in cycle 22; no response for the cycle-21 op in cycle 23; both readies are 0 in cycle 22.
- Async reset: rst_n pulsed low mid-cycle with two ops in flight -> rspN_valid drops immediately and alu_* = 0; no responses after release until a new accept plus 2 cycles.
- Idle hold: one accept of sub {func7 1, op1 9, op2 3}, then idle -> alu_* remain 01100/000/1/9/3; exactly one response (data 6), then rsp valids stay 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port arbiter and issue sequencer sharing one combinational ALU.
// Registers the granted operation onto the ALU inputs and returns the result two cycles after accept.
`default_nettype none

module alu_arbiter #(
    parameter int PRIO_MODE    = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_opcode,
    input  logic [2:0]  req0_func3,
    input  logic        req0_func7,
    input  logic [31:0] req0_op1,
    input  logic [31:0] req0_op2,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_opcode,
    input  logic [2:0]  req1_func3,
    input  logic        req1_func7,
    input  logic [31:0] req1_op1,
    input  logic [31:0] req1_op2,
    output logic [4:0]  alu_opcode,
    output logic [2:0]  alu_func3,
    output logic        alu_func7,
    output logic [31:0] alu_operand1,
    output logic [31:0] alu_operand2,
    input  logic [31:0] alu_result,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_data
);

    localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_LIMIT);

    logic        grant0, grant1;
    logic        last_grant_q, last_grant_d;
    logic [3:0]  starve_q, starve_d;
    logic [4:0]  alu_opcode_q;
    logic [2:0]  alu_func3_q;
    logic        alu_func7_q;
    logic [31:0] alu_op1_q, alu_op2_q;
    logic        s1_valid_q, s1_port_q;
    logic        s2_valid_q, s2_port_q;
    logic [31:0] rsp_data_q;

    // Grant depends only on the request valids, flush and registered arbitration state.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!flush) begin
            if (req0_valid && req1_valid) begin
                if (PRIO_MODE == 0) begin
                    if (last_grant_q) grant0 = 1'b1;
                    else              grant1 = 1'b1;
                end else begin
                    if (starve_q == C_STARVE_MAX) grant1 = 1'b1;
                    else                          grant0 = 1'b1;
                end
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        starve_d     = starve_q;
        if (grant0) last_grant_d = 1'b0;
        if (grant1) last_grant_d = 1'b1;
        // Flush cycles leave the starvation counter untouched.
        if (!flush) begin
            if (grant1)
                starve_d = 4'd0;
            else if (req1_valid && (starve_q < C_STARVE_MAX))
                starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            starve_q     <= 4'd0;
            alu_opcode_q <= 5'd0;
            alu_func3_q  <= 3'd0;
            alu_func7_q  <= 1'b0;
            alu_op1_q    <= 32'd0;
            alu_op2_q    <= 32'd0;
            s1_valid_q   <= 1'b0;
            s1_port_q    <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_port_q    <= 1'b0;
            rsp_data_q   <= 32'd0;
        end else begin
            last_grant_q <= last_grant_d;
            starve_q     <= starve_d;
            s1_valid_q   <= grant0 || grant1;
            if (grant1) begin
                alu_opcode_q <= req1_opcode;
                alu_func3_q  <= req1_func3;
                alu_func7_q  <= req1_func7;
                alu_op1_q    <= req1_op1;
                alu_op2_q    <= req1_op2;
                s1_port_q    <= 1'b1;
            end else if (grant0) begin
                alu_opcode_q <= req0_opcode;
                alu_func3_q  <= req0_func3;
                alu_func7_q  <= req0_func7;
                alu_op1_q    <= req0_op1;
                alu_op2_q    <= req0_op2;
                s1_port_q    <= 1'b0;
            end
            s2_valid_q <= s1_valid_q && !flush;
            s2_port_q  <= s1_port_q;
            rsp_data_q <= alu_result;
        end
    end

    assign req0_ready   = grant0;
    assign req1_ready   = grant1;
    assign alu_opcode   = alu_opcode_q;
    assign alu_func3    = alu_func3_q;
    assign alu_func7    = alu_func7_q;
    assign alu_operand1 = alu_op1_q;
    assign alu_operand2 = alu_op2_q;
    assign rsp0_valid   = s2_valid_q && !s2_port_q;
    assign rsp1_valid   = s2_valid_q && s2_port_q;
    assign rsp_data     = rsp_data_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter in round-robin and fixed-priority modes.
`default_nettype none

module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_opcode, req1_opcode;
    logic [2:0]  req0_func3, req1_func3;
    logic        req0_func7, req1_func7;
    logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;

    logic        rr_ready0, rr_ready1, rr_rsp0, rr_rsp1, rr_f7;
    logic [4:0]  rr_opc;
    logic [2:0]  rr_f3;
    logic [31:0] rr_a, rr_b, rr_res, rr_data;

    logic        fp_ready0, fp_ready1, fp_rsp0, fp_rsp1, fp_f7;
    logic [4:0]  fp_opc;
    logic [2:0]  fp_f3;
    logic [31:0] fp_a, fp_b, fp_res, fp_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Reference ALU: add/sub on func3 000 selected by func7, xor otherwise.
    function automatic logic [31:0] alu_model(input logic [2:0] f3, input logic f7,
                                              input logic [31:0] a, input logic [31:0] b);
        if (f3 == 3'b000) return f7 ? (a - b) : (a + b);
        return a ^ b;
    endfunction

    assign rr_res = alu_model(rr_f3, rr_f7, rr_a, rr_b);
    assign fp_res = alu_model(fp_f3, fp_f7, fp_a, fp_b);

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(rr_ready0), .req0_opcode(req0_opcode),
        .req0_func3(req0_func3), .req0_func7(req0_func7), .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req1_valid(req1_valid), .req1_ready(rr_ready1), .req1_opcode(req1_opcode),
        .req1_func3(req1_func3), .req1_func7(req1_func7), .req1_op1(req1_op1), .req1_op2(req1_op2),
        .alu_opcode(rr_opc), .alu_func3(rr_f3), .alu_func7(rr_f7),
        .alu_operand1(rr_a), .alu_operand2(rr_b), .alu_result(rr_res),
        .rsp0_valid(rr_rsp0), .rsp1_valid(rr_rsp1), .rsp_data(rr_data)
    );

    alu_arbiter #(.PRIO_MODE(1), .STARVE_LIMIT(4)) dut_fp (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(fp_ready0), .req0_opcode(req0_opcode),
        .req0_func3(req0_func3), .req0_func7(req0_func7), .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req1_valid(req1_valid), .req1_ready(fp_ready1), .req1_opcode(req1_opcode),
        .req1_func3(req1_func3), .req1_func7(req1_func7), .req1_op1(req1_op1), .req1_op2(req1_op2),
        .alu_opcode(fp_opc), .alu_func3(fp_f3), .alu_func7(fp_f7),
        .alu_operand1(fp_a), .alu_operand2(fp_b), .alu_result(fp_res),
        .rsp0_valid(fp_rsp0), .rsp1_valid(fp_rsp1), .rsp_data(fp_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Each cycle: inputs change 1 time unit after the rising edge, checks 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 1'b0;
        req0_valid = 1'b0; req0_opcode = 5'd0; req0_func3 = 3'd0; req0_func7 = 1'b0;
        req0_op1 = 32'd0;  req0_op2 = 32'd0;
        req1_valid = 1'b0; req1_opcode = 5'd0; req1_func3 = 3'd0; req1_func7 = 1'b0;
        req1_op1 = 32'd0;  req1_op2 = 32'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_req0(input logic f7, input logic [31:0] a, input logic [31:0] b);
        req0_valid = 1'b1; req0_opcode = 5'b01100; req0_func3 = 3'b000;
        req0_func7 = f7; req0_op1 = a; req0_op2 = b;
    endtask

    task automatic set_req1(input logic f7, input logic [31:0] a, input logic [31:0] b);
        req1_valid = 1'b1; req1_opcode = 5'b01100; req1_func3 = 3'b000;
        req1_func7 = f7; req1_op1 = a; req1_op2 = b;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) tick();
        #1;
        chk("reset_alu_opcode", 32'(rr_opc), 32'd0);
        chk("reset_alu_op1", rr_a, 32'd0);
        chk("reset_rsp_data", rr_data, 32'd0);
        chk("reset_rsp0", 32'(rr_rsp0), 32'd0);
        chk("reset_rsp1", 32'(fp_rsp1), 32'd0);
        tick();
        rst_n = 1'b1;

        // Single add on port 0
        set_req0(1'b0, 32'd5, 32'd7);
        #1;
        chk("single_ready0", 32'(rr_ready0), 32'd1);
        chk("single_ready1", 32'(rr_ready1), 32'd0);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("single_alu_opcode", 32'(rr_opc), 32'b01100);
        chk("single_alu_op1", rr_a, 32'd5);
        chk("single_alu_op2", rr_b, 32'd7);
        chk("single_rsp0_early", 32'(rr_rsp0), 32'd0);
        tick();
        #1;
        chk("single_rsp0", 32'(rr_rsp0), 32'd1);
        chk("single_rsp1", 32'(rr_rsp1), 32'd0);
        chk("single_data", rr_data, 32'd12);
        tick();
        #1;
        chk("single_rsp0_after", 32'(rr_rsp0), 32'd0);

        // Continuous contention: round-robin alternates, fixed priority gives port 1 every 5th slot
        do_reset();
        set_req0(1'b0, 32'd100, 32'd200);
        set_req1(1'b1, 32'd50, 32'd20);
        for (int i = 0; i < 12; i++) begin
            if (i == 10) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            #1;
            if (i < 10) begin
                chk($sformatf("rr_ready0_c%0d", i), 32'(rr_ready0), 32'((i % 2) == 0));
                chk($sformatf("rr_ready1_c%0d", i), 32'(rr_ready1), 32'((i % 2) == 1));
                chk($sformatf("fp_ready0_c%0d", i), 32'(fp_ready0), 32'((i % 5) != 4));
                chk($sformatf("fp_ready1_c%0d", i), 32'(fp_ready1), 32'((i % 5) == 4));
            end
            if (i >= 2) begin
                chk($sformatf("rr_rsp0_c%0d", i), 32'(rr_rsp0), 32'((i % 2) == 0));
                chk($sformatf("rr_rsp1_c%0d", i), 32'(rr_rsp1), 32'((i % 2) == 1));
                chk($sformatf("rr_data_c%0d", i), rr_data, ((i % 2) == 0) ? 32'd300 : 32'd30);
                chk($sformatf("fp_rsp1_c%0d", i), 32'(fp_rsp1), 32'(((i - 2) % 5) == 4));
                chk($sformatf("fp_data_c%0d", i), fp_data, (((i - 2) % 5) == 4) ? 32'd30 : 32'd300);
            end
            tick();
        end

        // Flush kills the younger op but the already-presented response survives
        set_req0(1'b0, 32'd1, 32'd2);
        #1;
        chk("flush_acc0_ready", 32'(rr_ready0), 32'd1);
        tick();
        req0_valid = 1'b0;
        set_req1(1'b1, 32'd10, 32'd4);
        #1;
        chk("flush_acc1_ready", 32'(rr_ready1), 32'd1);
        tick();
        flush = 1'b1;
        req0_valid = 1'b1;
        #1;
        chk("flush_ready0", 32'(rr_ready0), 32'd0);
        chk("flush_ready1", 32'(rr_ready1), 32'd0);
        chk("flush_rsp0_kept", 32'(rr_rsp0), 32'd1);
        chk("flush_rsp0_data", rr_data, 32'd3);
        tick();
        idle_inputs();
        #1;
        chk("flush_rsp1_killed", 32'(rr_rsp1), 32'd0);
        chk("flush_rsp0_after", 32'(rr_rsp0), 32'd0);
        tick();
        #1;
        chk("flush_rsp1_later", 32'(rr_rsp1), 32'd0);
        tick();

        // Async reset with two ops in flight
        set_req0(1'b0, 32'd8, 32'd8);
        tick();
        req0_valid = 1'b0;
        set_req1(1'b0, 32'd2, 32'd2);
        tick();
        req1_valid = 1'b0;
        #1;
        chk("areset_rsp0_before", 32'(rr_rsp0), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_rsp0_drop", 32'(rr_rsp0), 32'd0);
        chk("areset_alu_opcode", 32'(rr_opc), 32'd0);
        chk("areset_alu_op1", rr_a, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("areset_quiet0_c%0d", i), 32'(rr_rsp0), 32'd0);
            chk($sformatf("areset_quiet1_c%0d", i), 32'(rr_rsp1), 32'd0);
            tick();
        end
        set_req0(1'b0, 32'd0, 32'd0);
        set_req1(1'b0, 32'd0, 32'd0);
        #1;
        chk("areset_first_contention", 32'(rr_ready0), 32'd1);
        tick();

        // Idle hold after a single subtract
        do_reset();
        set_req0(1'b1, 32'd9, 32'd3);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("hold_func7", 32'(rr_f7), 32'd1);
        chk("hold_op1", rr_a, 32'd9);
        tick();
        #1;
        chk("hold_rsp0", 32'(rr_rsp0), 32'd1);
        chk("hold_data", rr_data, 32'd6);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk($sformatf("hold_rsp0_idle_c%0d", i), 32'(rr_rsp0), 32'd0);
            chk($sformatf("hold_rsp1_idle_c%0d", i), 32'(rr_rsp1), 32'd0);
            chk($sformatf("hold_opcode_c%0d", i), 32'(rr_opc), 32'b01100);
            chk($sformatf("hold_func3_c%0d", i), 32'(rr_f3), 32'd0);
            chk($sformatf("hold_func7_c%0d", i), 32'(rr_f7), 32'd1);
            chk($sformatf("hold_op1_c%0d", i), rr_a, 32'd9);
            chk($sformatf("hold_op2_c%0d", i), rr_b, 32'd3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
